// File: rtl/battle_core.sv
// battle_core: turn-based bullet-dodge battle engine.
// Menu/aim/damage/dodge FSM, player avatar and an 8-slot bullet field with collision.

module battle_slot #(
  parameter int IDX = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_init,
  input  logic       i_clear,
  input  logic       i_step,
  input  logic       i_chk,
  input  logic [7:0] i_px,
  input  logic [7:0] i_py,
  output logic       o_act,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic       o_hit
);
  localparam logic [7:0] X0  = 8'(16 * IDX + 4);
  localparam logic [7:0] SPD = 8'(2 + (IDX % 4));

  logic       r_act;
  logic [7:0] r_x, r_y;
  logic [7:0] w_dx, w_dy, w_ny;

  assign w_dx  = (i_px >= r_x) ? (i_px - r_x) : (r_x - i_px);
  assign w_dy  = (i_py >= r_y) ? (i_py - r_y) : (r_y - i_py);
  assign w_ny  = r_y + SPD;
  assign o_hit = i_chk && r_act && (w_dx < 8'd8) && (w_dy < 8'd8);
  assign o_act = r_act;
  assign o_x   = r_x;
  assign o_y   = r_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_act <= 1'b0;
      r_x   <= 8'd0;
      r_y   <= 8'd0;
    end else if (i_init) begin
      r_act <= 1'b1;
      r_x   <= X0;
      r_y   <= 8'd0;
    end else begin
      // a slot struck this cycle freezes where it was hit
      if (i_step && r_act && !o_hit) r_y <= (w_ny >= 8'd124) ? 8'd0 : w_ny;
      if (i_clear || o_hit) r_act <= 1'b0;
    end
  end
endmodule

module battle_core #(
  parameter int P_HP_MAX    = 100,
  parameter int M_HP_MAX    = 100,
  parameter int DODGE_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [7:0]  key,
  input  logic        keyValid,
  input  logic [2:0]  index,
  output logic [15:0] playerPos,
  output logic [15:0] bulletPos,
  output logic [15:0] bulletSize,
  output logic [2:0]  bulletColor,
  output logic        isRender,
  output logic [7:0]  pHP,
  output logic [7:0]  monHP,
  output logic [7:0]  mstate,
  output logic        isDeath
);
  localparam int         CW   = $clog2(DODGE_TICKS + 1);
  localparam logic [7:0] PHP0 = 8'(P_HP_MAX);
  localparam logic [7:0] MHP0 = 8'(M_HP_MAX);

  typedef enum logic [2:0] {
    MENU = 3'd0, AIM = 3'd1, DAMAGE = 3'd2, DODGE = 3'd3, WIN = 3'd4, LOSE = 3'd5
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_php, r_mon, r_px, r_py;
  logic [3:0]    r_cur;
  logic [4:0]    r_dmg;
  logic [CW-1:0] r_cnt;
  logic          r_isdeath;

  logic w_kf, w_kh, w_kspc, w_kw, w_ks, w_ka, w_kd;
  assign w_kf   = keyValid && (key == 8'h66);
  assign w_kh   = keyValid && (key == 8'h68);
  assign w_kspc = keyValid && (key == 8'h20);
  assign w_kw   = keyValid && (key == 8'h77);
  assign w_ks   = keyValid && (key == 8'h73);
  assign w_ka   = keyValid && (key == 8'h61);
  assign w_kd   = keyValid && (key == 8'h64);

  logic [8:0] w_heal_sum;
  logic [7:0] w_heal;
  assign w_heal_sum = {1'b0, r_php} + 9'd20;
  assign w_heal     = (w_heal_sum > {1'b0, PHP0}) ? PHP0 : w_heal_sum[7:0];

  // damage falls off linearly with cursor distance from centre (8)
  logic [3:0] w_off;
  logic [4:0] w_dmg_calc;
  logic [7:0] w_mon_dmg;
  assign w_off      = (r_cur >= 4'd8) ? (r_cur - 4'd8) : (4'd8 - r_cur);
  assign w_dmg_calc = 5'd20 - {w_off, 1'b0};
  assign w_mon_dmg  = (r_mon > {3'b0, r_dmg}) ? (r_mon - {3'b0, r_dmg}) : 8'd0;

  logic             w_dodge, w_enter, w_clear, w_step, w_dodge_end;
  logic [7:0]       w_act, w_hit;
  logic [7:0][7:0]  w_bx, w_by;
  logic [3:0]       w_nhit;
  logic [7:0]       w_hit_hp, w_php_hit;

  assign w_dodge     = (r_state == DODGE);
  assign w_step      = w_dodge && tick;
  assign w_dodge_end = tick && (r_cnt == CW'(DODGE_TICKS - 1));

  always_comb begin
    w_nhit = 4'd0;
    for (int i = 0; i < 8; i++) w_nhit = w_nhit + {3'b0, w_hit[i]};
  end
  assign w_hit_hp  = {2'b0, w_nhit, 2'b0} + {4'b0, w_nhit};
  assign w_php_hit = (r_php > w_hit_hp) ? (r_php - w_hit_hp) : 8'd0;

  for (genvar g = 0; g < 8; g++) begin : g_slot
    battle_slot #(.IDX(g)) u_slot (
      .clk    (clk),
      .reset  (reset),
      .i_init (w_enter),
      .i_clear(w_clear),
      .i_step (w_step),
      .i_chk  (w_dodge),
      .i_px   (r_px),
      .i_py   (r_py),
      .o_act  (w_act[g]),
      .o_x    (w_bx[g]),
      .o_y    (w_by[g]),
      .o_hit  (w_hit[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= MENU;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      MENU: begin
        if (w_kf) w_next = AIM;
        else if (w_kh) begin
          w_next  = DODGE;
          w_enter = 1'b1;
        end
      end
      AIM:    if (w_kspc) w_next = DAMAGE;
      DAMAGE: begin
        if (w_mon_dmg == 8'd0) w_next = WIN;
        else begin
          w_next  = DODGE;
          w_enter = 1'b1;
        end
      end
      // death outranks the end of the phase
      DODGE: begin
        if (w_php_hit == 8'd0) w_next = LOSE;
        else if (w_dodge_end)  w_next = MENU;
      end
      default: ;
    endcase
  end
  assign w_clear = w_dodge && (w_next == MENU);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_php     <= PHP0;
      r_mon     <= MHP0;
      r_px      <= 8'd60;
      r_py      <= 8'd100;
      r_cur     <= 4'd0;
      r_dmg     <= 5'd0;
      r_cnt     <= '0;
      r_isdeath <= 1'b0;
    end else begin
      r_isdeath <= (w_next == LOSE);
      case (r_state)
        MENU: begin
          if (w_kf)      r_cur <= 4'd0;
          else if (w_kh) r_php <= w_heal;
        end
        AIM: begin
          if (w_kspc)    r_dmg <= w_dmg_calc;
          else if (tick) r_cur <= r_cur + 4'd1;
        end
        DAMAGE: r_mon <= w_mon_dmg;
        DODGE: begin
          r_php <= w_php_hit;
          if (tick) r_cnt <= r_cnt + CW'(1);
          if (w_kw)      r_py <= (r_py < 8'd4)   ? 8'd0   : r_py - 8'd4;
          else if (w_ks) r_py <= (r_py > 8'd116) ? 8'd120 : r_py + 8'd4;
          else if (w_ka) r_px <= (r_px < 8'd4)   ? 8'd0   : r_px - 8'd4;
          else if (w_kd) r_px <= (r_px > 8'd116) ? 8'd120 : r_px + 8'd4;
        end
        default: ;
      endcase
      if (w_enter) begin
        r_px  <= 8'd60;
        r_py  <= 8'd100;
        r_cnt <= '0;
      end
    end
  end

  assign playerPos   = {r_px, r_py};
  assign bulletPos   = {w_bx[index], w_by[index]};
  assign bulletSize  = {8'd8, 8'd8};
  assign bulletColor = index;
  assign isRender    = w_act[index];
  assign pHP         = r_php;
  assign monHP       = r_mon;
  assign mstate      = {5'd0, r_state};
  assign isDeath     = r_isdeath;
endmodule

// File: tb/tb_battle_core.sv
// Self-checking bench for battle_core: directed vector table, hand sequences
// for win/lose, then randomized play against a behavioural game model.

module tb_battle_core;
  logic        clk = 1'b0;
  logic        reset, tick, keyValid;
  logic [7:0]  key;
  logic [2:0]  index;
  logic [15:0] playerPos, bulletPos, bulletSize;
  logic [2:0]  bulletColor;
  logic        isRender, isDeath;
  logic [7:0]  pHP, monHP, mstate;

  battle_core dut (
    .clk(clk), .reset(reset), .tick(tick), .key(key), .keyValid(keyValid),
    .index(index), .playerPos(playerPos), .bulletPos(bulletPos),
    .bulletSize(bulletSize), .bulletColor(bulletColor), .isRender(isRender),
    .pHP(pHP), .monHP(monHP), .mstate(mstate), .isDeath(isDeath)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural game model ----------------
  int m_st, m_php, m_mon, m_px, m_py, m_cur, m_dmg, m_cnt;
  int m_act[8], m_bx[8], m_by[8];

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic mdl_enter();
    m_st = 3; m_px = 60; m_py = 100; m_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 1; m_bx[i] = 16 * i + 4; m_by[i] = 0;
    end
  endtask

  task automatic mdl_step(bit rst, bit kv, logic [7:0] k, bit tk);
    int hits;
    if (rst) begin
      m_st = 0; m_php = 100; m_mon = 100; m_px = 60; m_py = 100;
      m_cur = 0; m_dmg = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) begin m_act[i] = 0; m_bx[i] = 0; m_by[i] = 0; end
      return;
    end
    case (m_st)
      0: begin
        if (kv && k == 8'h66) begin m_st = 1; m_cur = 0; end
        else if (kv && k == 8'h68) begin
          m_php = (m_php + 20 > 100) ? 100 : m_php + 20;
          mdl_enter();
        end
      end
      1: begin
        if (kv && k == 8'h20) begin m_dmg = 20 - 2 * iabs(m_cur - 8); m_st = 2; end
        else if (tk) m_cur = (m_cur + 1) % 16;
      end
      2: begin
        m_mon = (m_mon > m_dmg) ? m_mon - m_dmg : 0;
        if (m_mon == 0) m_st = 4; else mdl_enter();
      end
      3: begin
        hits = 0;
        for (int i = 0; i < 8; i++)
          if (m_act[i] != 0 && iabs(m_px - m_bx[i]) < 8 && iabs(m_py - m_by[i]) < 8) begin
            hits++; m_act[i] = 0;
          end
        if (kv) begin
          if (k == 8'h77) m_py = (m_py - 4 < 0) ? 0 : m_py - 4;
          if (k == 8'h73) m_py = (m_py + 4 > 120) ? 120 : m_py + 4;
          if (k == 8'h61) m_px = (m_px - 4 < 0) ? 0 : m_px - 4;
          if (k == 8'h64) m_px = (m_px + 4 > 120) ? 120 : m_px + 4;
        end
        if (tk) begin
          for (int i = 0; i < 8; i++)
            if (m_act[i] != 0) begin
              m_by[i] += 2 + (i % 4);
              if (m_by[i] >= 124) m_by[i] = 0;
            end
          m_cnt++;
        end
        m_php = (m_php > 5 * hits) ? m_php - 5 * hits : 0;
        if (m_php == 0) m_st = 5;
        else if (tk && m_cnt == 64) begin
          m_st = 0;
          for (int i = 0; i < 8; i++) m_act[i] = 0;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- helpers ----------------
  task automatic check(string nm, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic cyc(bit rst, bit kv, logic [7:0] k, bit tk);
    reset = rst; keyValid = kv; key = k; tick = tk;
    @(posedge clk); #1;
    mdl_step(rst, kv, k, tk);
    reset = 1'b0; keyValid = 1'b0; tick = 1'b0;
  endtask

  task automatic chk_slot(string nm, int i, int exp_r, int exp_pos);
    index = 3'(i); #1;
    check($sformatf("%s.render%0d", nm, i), int'(isRender), exp_r);
    check($sformatf("%s.bpos%0d", nm, i), int'(bulletPos), exp_pos);
    check($sformatf("%s.color%0d", nm, i), int'(bulletColor), i);
  endtask

  typedef struct {
    bit         kv;
    logic [7:0] k;
    bit         tk;
    int         rep;
    int         st, php, mon, pos;
  } vec_t;

  function automatic vec_t v(bit kv, logic [7:0] k, bit tk, int rep,
                             int st, int php, int mon, int pos);
    vec_t t;
    t.kv = kv; t.k = k; t.tk = tk; t.rep = rep;
    t.st = st; t.php = php; t.mon = mon; t.pos = pos;
    return t;
  endfunction

  task automatic run_vec(int n, vec_t t);
    for (int r = 0; r < t.rep; r++) begin
      cyc(1'b0, t.kv, t.k, t.tk);
      check($sformatf("vec%0d.%0d.state", n, r), int'(mstate), t.st);
      check($sformatf("vec%0d.%0d.pHP", n, r), int'(pHP), t.php);
      check($sformatf("vec%0d.%0d.monHP", n, r), int'(monHP), t.mon);
      check($sformatf("vec%0d.%0d.ppos", n, r), int'(playerPos), t.pos);
    end
  endtask

  task automatic chk_reset(string nm);
    check({nm, ".state"}, int'(mstate), 0);
    check({nm, ".pHP"}, int'(pHP), 100);
    check({nm, ".monHP"}, int'(monHP), 100);
    check({nm, ".ppos"}, int'(playerPos), 16'h3C64);
    check({nm, ".death"}, int'(isDeath), 0);
    check({nm, ".bsize"}, int'(bulletSize), 16'h0808);
    for (int i = 0; i < 8; i++) chk_slot(nm, i, 0, 0);
  endtask

  vec_t tbl[$];
  logic [7:0] rkeys [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; keyValid = 1'b0; key = 8'h00; index = 3'd0;
    rkeys[0] = 8'h66; rkeys[1] = 8'h68; rkeys[2] = 8'h20; rkeys[3] = 8'h77;
    rkeys[4] = 8'h73; rkeys[5] = 8'h61; rkeys[6] = 8'h64; rkeys[7] = 8'h41;

    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    chk_reset("reset");

    // fight at cursor 8, idle dodge, heal-dodge with one left step and a hit
    tbl.push_back(v(1, 8'h66, 0, 1,  1, 100, 100, 16'h3C64));
    tbl.push_back(v(0, 8'h00, 1, 8,  1, 100, 100, 16'h3C64));
    tbl.push_back(v(1, 8'h20, 0, 1,  2, 100, 100, 16'h3C64));
    tbl.push_back(v(0, 8'h00, 0, 1,  3, 100,  80, 16'h3C64));
    tbl.push_back(v(0, 8'h00, 1, 63, 3, 100,  80, 16'h3C64));
    tbl.push_back(v(0, 8'h00, 1, 1,  0, 100,  80, 16'h3C64));
    tbl.push_back(v(1, 8'h68, 0, 1,  3, 100,  80, 16'h3C64));
    tbl.push_back(v(1, 8'h61, 0, 1,  3, 100,  80, 16'h3864));
    tbl.push_back(v(0, 8'h00, 1, 19, 3, 100,  80, 16'h3864));
    tbl.push_back(v(0, 8'h00, 1, 1,  3,  95,  80, 16'h3864));
    tbl.push_back(v(0, 8'h00, 1, 40, 3,  95,  80, 16'h3864));
    tbl.push_back(v(0, 8'h00, 1, 3,  3,  95,  80, 16'h3864));
    tbl.push_back(v(0, 8'h00, 1, 1,  0,  95,  80, 16'h3864));
    tbl.push_back(v(1, 8'h68, 0, 1,  3, 100,  80, 16'h3C64));

    for (int n = 0; n < tbl.size(); n++) begin
      run_vec(n, tbl[n]);
      if (n == 6)
        for (int i = 0; i < 8; i++) chk_slot("heal_entry", i, 1, ((16 * i + 4) << 8));
      if (n == 9 || n == 10) chk_slot($sformatf("hit%0d", n), 3, 0, 16'h345F);
      if (n == 12)
        for (int i = 0; i < 8; i++) begin
          index = 3'(i); #1;
          check($sformatf("phase_end.render%0d", i), int'(isRender), 0);
        end
    end

    // five rounds to a win, then keys are ignored
    cyc(1, 0, 8'h00, 0);
    chk_reset("reset2");
    for (int r = 1; r <= 5; r++) begin
      cyc(0, 1, 8'h66, 0);
      for (int t = 0; t < 8; t++) cyc(0, 0, 8'h00, 1);
      cyc(0, 1, 8'h20, 0);
      check($sformatf("win%0d.damage_state", r), int'(mstate), 2);
      cyc(0, 0, 8'h00, 0);
      check($sformatf("win%0d.monHP", r), int'(monHP), 100 - 20 * r);
      check($sformatf("win%0d.state", r), int'(mstate), (r < 5) ? 3 : 4);
      if (r < 5) begin
        for (int t = 0; t < 64; t++) cyc(0, 0, 8'h00, 1);
        check($sformatf("win%0d.menu", r), int'(mstate), 0);
      end
    end
    cyc(0, 1, 8'h66, 1);
    check("win.f_ignored", int'(mstate), 4);
    cyc(0, 1, 8'h68, 0);
    check("win.h_ignored", int'(pHP), 100);
    check("win.no_death", int'(isDeath), 0);

    // one hit per phase until death
    cyc(1, 0, 8'h00, 0);
    for (int r = 1; r <= 20; r++) begin
      cyc(0, 1, 8'h66, 0);
      cyc(0, 1, 8'h20, 0);
      cyc(0, 0, 8'h00, 0);
      check($sformatf("lose%0d.monHP", r), int'(monHP), 100 - 4 * r);
      cyc(0, 1, 8'h61, 0);
      for (int t = 0; t < 70 && mstate == 8'd3; t++) cyc(0, 0, 8'h00, 1);
      check($sformatf("lose%0d.pHP", r), int'(pHP), 100 - 5 * r);
      check($sformatf("lose%0d.state", r), int'(mstate), (r < 20) ? 0 : 5);
    end
    check("lose.death", int'(isDeath), 1);
    cyc(0, 1, 8'h68, 0);
    check("lose.h_ignored", int'(pHP), 0);
    check("lose.terminal", int'(mstate), 5);

    // randomized play against the model
    cyc(1, 0, 8'h00, 0);
    for (int c = 0; c < 4000; c++) begin
      bit rst, kv, tk;
      rst   = ($urandom_range(0, 399) == 0);
      kv    = ($urandom_range(0, 2) == 0);
      tk    = $urandom_range(0, 1) == 1;
      index = 3'($urandom_range(0, 7));
      cyc(rst, kv, rkeys[$urandom_range(0, 7)], tk);
      check($sformatf("rnd%0d.state", c), int'(mstate), m_st);
      check($sformatf("rnd%0d.pHP", c), int'(pHP), m_php);
      check($sformatf("rnd%0d.monHP", c), int'(monHP), m_mon);
      check($sformatf("rnd%0d.ppos", c), int'(playerPos), (m_px << 8) | m_py);
      check($sformatf("rnd%0d.render", c), int'(isRender), m_act[index]);
      check($sformatf("rnd%0d.bpos", c), int'(bulletPos), (m_bx[index] << 8) | m_by[index]);
      check($sformatf("rnd%0d.death", c), int'(isDeath), (m_st == 5) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
